// File: rtl/tnn_vote_argmax.sv
// Per-class vote accumulator and argmax. Result is valid N_CLASS+1 cycles after the last beat.
// in_ready is low while scanning or holding; the result is held until out_ready.
module tnn_vote_argmax #(
    parameter int N_CLASS = 7,
    parameter int CNT_W   = 6,
    localparam int IDX_W  = (N_CLASS > 1) ? $clog2(N_CLASS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_CLASS-1:0] in_fire,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_class,
    output logic [CNT_W-1:0]   out_score
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASS - 1);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_SCAN  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0] cnt [N_CLASS];
    logic [IDX_W-1:0] scan_idx;
    logic [CNT_W-1:0] best_cnt;
    logic [IDX_W-1:0] best_idx;

    logic             beat_acc;
    logic             scan_done;
    logic             handoff;
    logic [CNT_W-1:0] scan_cnt;
    logic             scan_take;
    logic [CNT_W-1:0] cand_cnt;
    logic [IDX_W-1:0] cand_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        beat_acc  = 1'b0;
        scan_done = 1'b0;
        handoff   = 1'b0;
        case (state)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    beat_acc = 1'b1;
                    if (in_last) begin
                        state_nxt = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                if (scan_idx == LAST_IDX) begin
                    scan_done = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    handoff   = 1'b1;
                    state_nxt = ST_ACCUM;
                end
            end
            default: begin
                state_nxt = ST_ACCUM;
            end
        endcase
    end

    // Strict greater-than keeps the earlier (lower) index on ties.
    always_comb begin
        scan_cnt  = cnt[scan_idx];
        scan_take = (scan_cnt > best_cnt);
        cand_cnt  = scan_take ? scan_cnt : best_cnt;
        cand_idx  = scan_take ? scan_idx : best_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_CLASS; k++) begin
                cnt[k] <= '0;
            end
            scan_idx  <= '0;
            best_cnt  <= '0;
            best_idx  <= '0;
            out_class <= '0;
            out_score <= '0;
        end else begin
            if (beat_acc) begin
                for (int k = 0; k < N_CLASS; k++) begin
                    if (in_fire[k] && (cnt[k] != CNT_MAX)) begin
                        cnt[k] <= cnt[k] + CNT_W'(1);
                    end
                end
                if (in_last) begin
                    scan_idx <= '0;
                    best_cnt <= '0;
                    best_idx <= '0;
                end
            end
            if (state == ST_SCAN) begin
                best_cnt <= cand_cnt;
                best_idx <= cand_idx;
                if (!scan_done) begin
                    scan_idx <= scan_idx + IDX_W'(1);
                end
                if (scan_done) begin
                    out_class <= cand_idx;
                    out_score <= cand_cnt;
                end
            end
            if (handoff) begin
                for (int k = 0; k < N_CLASS; k++) begin
                    cnt[k] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tnn_vote_argmax.sv
// Directed and random stimulus for tnn_vote_argmax against a per-sample argmax reference model.
module tb_tnn_vote_argmax;

    localparam int N   = 7;
    localparam int W   = 6;
    localparam int IW  = 3;
    localparam int MAX = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_fire = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] out_class;
    logic [W-1:0]  out_score;

    tnn_vote_argmax #(.N_CLASS(N), .CNT_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fire   (in_fire),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_score (out_score)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: vote totals, cycles of scanning left, and the visible result.
    int m_cnt [N];
    int m_scan_left = 0;
    bit m_hold = 1'b0;
    int exp_cls = 0;
    int exp_score = 0;
    int pend_cls = 0;
    int pend_score = 0;
    int lat = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
    endtask

    task automatic step(input logic v, input logic [N-1:0] f, input logic l,
                        input logic ordy, input logic r);
        @(negedge clk);
        rst = r; in_valid = v; in_fire = f; in_last = l; out_ready = ordy;
        chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_hold && m_scan_left == 0)});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_hold});
        chk("out_class", {29'd0, out_class}, exp_cls);
        chk("out_score", {26'd0, out_score}, exp_score);
        if (lat >= 0) begin
            lat++;
            if (out_valid || lat > N + 4) begin
                chk("latency", lat, N + 1);
                lat = -1;
            end
        end
        @(posedge clk);
        if (r) begin
            model_clear();
            m_scan_left = 0; m_hold = 0; exp_cls = 0; exp_score = 0; lat = -1;
        end else if (!m_hold && m_scan_left == 0) begin
            if (v) begin
                for (int k = 0; k < N; k++) begin
                    m_cnt[k] = m_cnt[k] + int'(f[k]);
                    if (m_cnt[k] > MAX) m_cnt[k] = MAX;
                end
                if (l) begin
                    pend_cls = 0; pend_score = 0;
                    for (int k = 0; k < N; k++) begin
                        if (m_cnt[k] > pend_score) begin
                            pend_score = m_cnt[k]; pend_cls = k;
                        end
                    end
                    m_scan_left = N;
                    lat = 0;
                end
            end
        end else if (m_scan_left > 0) begin
            m_scan_left--;
            if (m_scan_left == 0) begin
                m_hold = 1; exp_cls = pend_cls; exp_score = pend_score;
            end
        end else if (ordy) begin
            m_hold = 0;
            model_clear();
        end
    endtask

    task automatic beat(input logic [N-1:0] f, input logic l);
        step(1'b1, f, l, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, N'($urandom), 1'b0, 1'b0, 1'b0);
    endtask

    // Run through scan and hold, keep out_ready low for hold_wait cycles, then hand off.
    task automatic drain(input int hold_wait, input bit noisy);
        int held;
        bit done;
        logic v, l, ordy;
        logic [N-1:0] f;
        held = 0; done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            f = N'($urandom);
            v = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            l = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (m_hold) ordy = (held >= hold_wait) && (!noisy || 1'($urandom_range(0, 1)));
            else        ordy = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (m_hold) held++;
            done = m_hold && ordy;
            step(v, f, l, ordy, 1'b0);
        end
        chk("drain_done", {31'd0, done}, 1);
    endtask

    task automatic chk_retained(input string tag, input int cls, input int score);
        @(negedge clk);
        in_valid = 0; out_ready = 0; in_last = 0;
        chk({tag, "_class"}, {29'd0, out_class}, cls);
        chk({tag, "_score"}, {26'd0, out_score}, score);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        model_clear();
        step(1'b1, 7'h7F, 1'b1, 1'b1, 1'b1);
        idle(2);

        // Class 2 collects three votes, class 1 only one.
        beat(7'h04, 1'b0);
        beat(7'h06, 1'b0);
        beat(7'h04, 1'b1);
        drain(0, 1'b0);
        chk_retained("s_basic", 2, 3);

        // Tie between class 1 and class 5.
        beat(7'h22, 1'b0);
        beat(7'h22, 1'b1);
        drain(1, 1'b0);
        chk_retained("s_tie", 1, 2);

        // Saturation of class 0.
        for (int i = 0; i < 70; i++) beat(7'h01, (i == 69));
        drain(2, 1'b0);
        chk_retained("s_sat", 0, MAX);

        // All-zero single-beat sample, held for 10 cycles.
        beat(7'h00, 1'b1);
        drain(10, 1'b0);
        chk_retained("s_zero", 0, 0);

        // Fresh sample after the long hold starts from zero counts.
        beat(7'h08, 1'b1);
        drain(0, 1'b0);
        chk_retained("s_fresh", 3, 1);

        // Reset mid-scan discards everything.
        beat(7'h3F, 1'b0);
        beat(7'h3F, 1'b1);
        idle(3);
        step(1'b1, 7'h7F, 1'b1, 1'b1, 1'b1);
        beat(7'h40, 1'b1);
        drain(0, 1'b0);
        chk_retained("s_rst", 6, 1);

        // Random in_valid with in_last on the fourth accepted beat; noise during scan/hold.
        for (int s = 0; s < 12; s++) begin
            int nv;
            logic v;
            nv = 0;
            while (nv < 4) begin
                v = 1'($urandom_range(0, 1));
                step(v, N'($urandom), (v && nv == 3), 1'($urandom_range(0, 1)), 1'b0);
                if (v) nv++;
            end
            drain($urandom_range(0, 4), 1'b1);
        end

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
